// File: rtl/weight_loader_if.sv
// ============================================================================
// Module      : weight_loader_if
// Description : Layer-select, ROM bus and image/status bundle for weight_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_loader_if #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 288,
    parameter int SEL_W    = 3,
    parameter int ADDR_W   = 11
);
    logic [SEL_W-1:0]          sel;
    logic                      reload;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_LEN-1:0]       rom_q;
    logic                      busy;
    logic                      valid;
    logic                      done;
    logic                      err;
    logic [DEPTH*DATA_LEN-1:0] q;

    // Host side: selects the layer and provides the ROM.
    modport master (
        output sel, reload, rom_q,
        input  rom_addr, busy, valid, done, err, q
    );

    modport slave (
        input  sel, reload, rom_q,
        output rom_addr, busy, valid, done, err, q
    );
endinterface

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module      : weight_loader
// Description : Streams one layer image out of a synchronous ROM into a wide
//               parallel weight register on every layer-select change/reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 288,
    parameter int NUM_LAYERS = 5,
    parameter int SEL_W      = 3,
    parameter int ADDR_W     = 11
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    weight_loader_if.slave  bus
);

    localparam int c_CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PROD_W = SEL_W + 32;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEPTH - 1);

    generate
        if (NUM_LAYERS * DEPTH > 2 ** ADDR_W) begin : g_bad_params
            $error("weight_loader: NUM_LAYERS*DEPTH exceeds the ROM address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state, w_nxt_state;
    logic [ADDR_W-1:0]   r_rom_addr, w_nxt_rom_addr;
    logic [c_CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [c_CNT_W-1:0]  r_wr_idx, w_nxt_wr_idx;
    logic [SEL_W-1:0]    r_sel_q;
    logic                r_pending, w_nxt_pending;
    logic                r_busy, w_nxt_busy;
    logic                r_valid, w_nxt_valid;
    logic                r_done, w_nxt_done;
    logic                r_err, w_nxt_err;
    logic [DATA_LEN-1:0] r_mem [DEPTH];

    logic                w_req;
    logic                w_sel_ok;
    logic                w_wr_en;
    logic [c_PROD_W-1:0] w_base_wide;

    assign w_req       = (bus.sel != r_sel_q) | bus.reload | r_pending;
    assign w_sel_ok    = (32'(bus.sel) < NUM_LAYERS);
    assign w_base_wide = c_PROD_W'(bus.sel) * c_PROD_W'(DEPTH);

    // ROM data lags its address by one cycle, so the first FETCH cycle has
    // nothing to store and DRAIN stores the last word. A request on the same
    // edge belongs to a load being abandoned, so its data is dropped.
    assign w_wr_en = !w_req &&
                     (((r_state == S_FETCH) && (r_cnt != '0)) || (r_state == S_DRAIN));

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_rom_addr = r_rom_addr;
        w_nxt_cnt      = r_cnt;
        w_nxt_wr_idx   = r_wr_idx;
        w_nxt_pending  = r_pending;
        w_nxt_busy     = r_busy;
        w_nxt_valid    = r_valid;
        w_nxt_done     = 1'b0;
        w_nxt_err      = r_err;

        if (w_req) begin
            if (w_sel_ok) begin
                w_nxt_state    = S_FETCH;
                w_nxt_rom_addr = w_base_wide[ADDR_W-1:0];
                w_nxt_cnt      = '0;
                w_nxt_wr_idx   = '0;
                w_nxt_pending  = 1'b0;
                w_nxt_busy     = 1'b1;
                w_nxt_valid    = 1'b0;
                w_nxt_err      = 1'b0;
            end else begin
                w_nxt_state = S_IDLE;
                w_nxt_busy  = 1'b0;
                w_nxt_valid = 1'b0;
                w_nxt_err   = 1'b1;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_cnt == c_LAST) begin
                        w_nxt_state = S_DRAIN;
                    end else begin
                        w_nxt_cnt      = r_cnt + c_CNT_W'(1);
                        w_nxt_rom_addr = r_rom_addr + ADDR_W'(1);
                    end
                    if (w_wr_en) begin
                        w_nxt_wr_idx = r_wr_idx + c_CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_busy  = 1'b0;
                    w_nxt_valid = 1'b1;
                    w_nxt_done  = 1'b1;
                end
                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_cnt      <= '0;
            r_wr_idx   <= '0;
            r_sel_q    <= '0;
            r_pending  <= 1'b1;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_rom_addr <= w_nxt_rom_addr;
            r_cnt      <= w_nxt_cnt;
            r_wr_idx   <= w_nxt_wr_idx;
            r_sel_q    <= bus.sel;
            r_pending  <= w_nxt_pending;
            r_busy     <= w_nxt_busy;
            r_valid    <= w_nxt_valid;
            r_done     <= w_nxt_done;
            r_err      <= w_nxt_err;
        end
    end

    // Image storage is deliberately not reset; it is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_idx] <= bus.rom_q;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign bus.q[gi*DATA_LEN +: DATA_LEN] = r_mem[gi];
        end
    endgenerate

    assign bus.rom_addr = r_rom_addr;
    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module      : tb_weight_loader
// Description : Randomized scoreboard bench for weight_loader against a ROM
//               whose word at address a is a[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_loader;

    localparam int DATA_LEN   = 8;
    localparam int DEPTH      = 4;
    localparam int NUM_LAYERS = 5;
    localparam int SEL_W      = 3;
    localparam int ADDR_W     = 11;
    localparam int QW         = DEPTH * DATA_LEN;

    logic clk;
    logic rst_n;

    weight_loader_if #(
        .DATA_LEN(DATA_LEN), .DEPTH(DEPTH), .SEL_W(SEL_W), .ADDR_W(ADDR_W)
    ) bus ();

    weight_loader #(
        .DATA_LEN(DATA_LEN), .DEPTH(DEPTH), .NUM_LAYERS(NUM_LAYERS),
        .SEL_W(SEL_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: word at address a is the low byte of a.
    always @(posedge clk) bus.rom_q <= bus.rom_addr[7:0];

    int n_checks = 0;
    int n_pass   = 0;
    logic [QW-1:0] sb[$];
    logic [QW-1:0] last_img;
    int cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [QW-1:0] image(input int s);
        logic [QW-1:0] img;
        for (int i = 0; i < DEPTH; i++) img[i*DATA_LEN +: DATA_LEN] = 8'(s * DEPTH + i);
        return img;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expected image.
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [QW-1:0] exp_img;
                exp_img = sb.pop_front();
                check("done_q", 64'(bus.q), 64'(exp_img));
                check("done_valid", 64'(bus.valid), 64'd1);
            end
        end
    end

    // Caller has set up the request on the preceding negedge; walks E0..E(DEPTH+1).
    task automatic timed_check(input int s);
        sb.push_back(image(s));
        for (int i = 0; i <= DEPTH + 1; i++) begin
            @(posedge clk);
            #1;
            bus.reload = 1'b0;
            check("t_busy",  64'(bus.busy),  64'(i <= DEPTH));
            check("t_valid", 64'(bus.valid), 64'(i == DEPTH + 1));
            check("t_done",  64'(bus.done),  64'(i == DEPTH + 1));
            if (i < DEPTH) check("t_rom_addr", 64'(bus.rom_addr), 64'(s * DEPTH + i));
        end
        last_img = image(s);
    endtask

    task automatic issue(input int s);
        @(negedge clk);
        bus.reload = (s == cur);
        bus.sel    = SEL_W'(s);
        cur        = s;
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("load_timeout", 64'(sb.size() == 0), 64'd1);
    endtask

    initial begin
        int a, b, bad, mode;
        rst_n      = 1'b0;
        bus.sel    = '0;
        bus.reload = 1'b0;
        cur        = 0;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_valid",    64'(bus.valid),    64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_err",      64'(bus.err),      64'd0);

        // Pending load of layer 0 after reset release.
        rst_n = 1'b1;
        timed_check(0);

        // Idle sel change to layer 3.
        @(negedge clk);
        bus.sel = 3'd3;
        cur     = 3;
        timed_check(3);

        // Abort layer 1 at its second FETCH cycle by switching to layer 2.
        issue(1);
        sb.push_back(image(2));
        issue(2);
        wait_done();
        last_img = image(2);

        // Out-of-range select leaves the image untouched.
        issue(6);
        check("err_set",   64'(bus.err),   64'd1);
        check("err_valid", 64'(bus.valid), 64'd0);
        check("err_busy",  64'(bus.busy),  64'd0);
        check("err_q",     64'(bus.q),     64'(last_img));
        repeat (3) @(negedge clk);
        check("err_q_hold", 64'(bus.q), 64'(last_img));
        check("err_sticky", 64'(bus.err), 64'd1);
        bus.sel = 3'd4;
        cur     = 4;
        timed_check(4);
        check("err_clear", 64'(bus.err), 64'd0);

        // Reload of an unchanged select.
        sb.push_back(image(2));
        issue(2);
        wait_done();
        @(negedge clk);
        bus.reload = 1'b1;
        timed_check(2);

        // Reload and select change on the same edge: one load of the new layer.
        @(negedge clk);
        bus.sel    = 3'd1;
        bus.reload = 1'b1;
        cur        = 1;
        timed_check(1);
        repeat (10) @(negedge clk);

        for (int it = 0; it < 30; it++) begin
            a    = int'($urandom_range(0, NUM_LAYERS - 1));
            b    = int'($urandom_range(0, NUM_LAYERS - 1));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    sb.push_back(image(a));
                    issue(a);
                    wait_done();
                    last_img = image(a);
                end
                1: begin
                    issue(a);
                    repeat (int'($urandom_range(0, DEPTH - 1))) @(negedge clk);
                    sb.push_back(image(b));
                    issue(b);
                    wait_done();
                    last_img = image(b);
                end
                2: begin
                    bad = int'($urandom_range(NUM_LAYERS, 7));
                    issue(bad);
                    check("rnd_err",   64'(bus.err),   64'd1);
                    check("rnd_valid", 64'(bus.valid), 64'd0);
                    check("rnd_q",     64'(bus.q),     64'(last_img));
                    sb.push_back(image(a));
                    issue(a);
                    check("rnd_err_clr", 64'(bus.err), 64'd0);
                    wait_done();
                    last_img = image(a);
                end
                default: begin
                    sb.push_back(image(cur));
                    issue(cur);
                    wait_done();
                    last_img = image(cur);
                end
            endcase
        end

        // Asynchronous reset in the middle of a fetch.
        issue(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",     64'(bus.busy),     64'd0);
        check("arst_rom_addr", 64'(bus.rom_addr), 64'd0);
        check("arst_valid",    64'(bus.valid),    64'd0);
        check("arst_done",     64'(bus.done),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        timed_check(3);

        repeat (10) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
